ripple_count_sampler: RTL and testbench

Synchronous consumer for the 3-bit asynchronous ripple up-counter. Brings the ripple outputs into the `clk` domain through a two-flop synchronizer and a stability filter, so ripple transients are never accepted. Derives a wrap pulse from the filtered count. Accumulates count increments over a fixed measurement window and hands each window result downstream on a valid/ready interface.

---
 rtl/ripple_pkg.sv | 20 ++
 rtl/ripple_sync_filter.sv | 50 +++++
 rtl/ripple_count_sampler.sv | 146 ++++++++++++++
 tb/tb_ripple_count_sampler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ripple_pkg.sv
// Shared definitions for the ripple counter sampling path: counter width,
// controller states and the modular delta helper.
package ripple_pkg;

    localparam int RIPPLE_W = 3;

    typedef enum logic {
        ACQ = 1'b0,
        RUN = 1'b1
    } state_e;

    // Forward distance from old_val to new_val on the wrapping ripple counter
    function automatic logic [RIPPLE_W-1:0] ripple_delta(
        input logic [RIPPLE_W-1:0] new_val,
        input logic [RIPPLE_W-1:0] old_val
    );
        return new_val - old_val;
    endfunction

endpackage

// File: rtl/ripple_sync_filter.sv
// Two-flop synchronizer for the asynchronous ripple outputs followed by an
// equal-sample filter that only accepts values seen on two consecutive cycles.
module ripple_sync_filter
    import ripple_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [RIPPLE_W-1:0] ripple_q,
    output logic [RIPPLE_W-1:0] acc_val,
    output logic                acc_stb
);

    logic [RIPPLE_W-1:0] s1_q, s1_d;
    logic [RIPPLE_W-1:0] s2_q, s2_d;
    logic [RIPPLE_W-1:0] p_q,  p_d;
    logic [1:0]          fill_q, fill_d;

    // Next-state for the sample pipeline and the pipeline fill tracker
    always_comb begin
        s1_d   = ripple_q;
        s2_d   = s1_q;
        p_d    = s2_q;
        fill_d = fill_q;
        if (fill_q != 2'd3) begin
            fill_d = fill_q + 2'd1;
        end else begin
            fill_d = fill_q;
        end
    end

    // Sample pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            p_q    <= '0;
            fill_q <= 2'd0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            p_q    <= p_d;
            fill_q <= fill_d;
        end
    end

    // The zero reset contents of s2/p would otherwise look like an accepted 0
    assign acc_val = s2_q;
    assign acc_stb = (fill_q == 2'd3) && (s2_q == p_q);

endmodule

// File: rtl/ripple_count_sampler.sv
// Synchronous consumer of the 3-bit ripple counter: filtered count, wrap pulse
// and per-window increment totals delivered over a valid/ready interface.
module ripple_count_sampler
    import ripple_pkg::*;
#(
    parameter int WIN_CYCLES = 1024,
    parameter int ACC_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RIPPLE_W-1:0] ripple_q,
    output logic [RIPPLE_W-1:0] cnt_stable,
    output logic                cnt_valid,
    output logic                wrap_pulse,
    output logic [ACC_W-1:0]    meas_data,
    output logic                meas_valid,
    input  logic                meas_ready,
    output logic                meas_ovf
);

    localparam int TMR_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_CYCLES - 1);

    logic [RIPPLE_W-1:0] acc_val;
    logic                acc_stb;

    ripple_sync_filter u_sync_filter (
        .clk      (clk),
        .rst      (rst),
        .ripple_q (ripple_q),
        .acc_val  (acc_val),
        .acc_stb  (acc_stb)
    );

    state_e              state_q,      state_d;
    logic [RIPPLE_W-1:0] cnt_stable_q, cnt_stable_d;
    logic                cnt_valid_q,  cnt_valid_d;
    logic                wrap_q,       wrap_d;
    logic [TMR_W-1:0]    timer_q,      timer_d;
    logic [ACC_W-1:0]    acc_q,        acc_d;
    logic [ACC_W-1:0]    meas_data_q,  meas_data_d;
    logic                meas_valid_q, meas_valid_d;
    logic                meas_ovf_q,   meas_ovf_d;

    logic                change;
    logic [RIPPLE_W-1:0] delta;
    logic [ACC_W:0]      sum_ext;
    logic [ACC_W-1:0]    sum_sat;
    logic                xfer;

    // Controller, window timer, saturating accumulator and result handshake
    always_comb begin
        state_d      = state_q;
        cnt_stable_d = cnt_stable_q;
        cnt_valid_d  = cnt_valid_q;
        wrap_d       = 1'b0;
        timer_d      = timer_q;
        acc_d        = acc_q;
        meas_data_d  = meas_data_q;
        meas_valid_d = meas_valid_q;
        meas_ovf_d   = meas_ovf_q;

        change  = acc_stb && (acc_val != cnt_stable_q);
        delta   = change ? ripple_delta(acc_val, cnt_stable_q) : 3'd0;
        sum_ext = {1'b0, acc_q} + {{(ACC_W-2){1'b0}}, delta};
        sum_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
        xfer    = meas_valid_q && meas_ready;

        if (xfer) begin
            meas_valid_d = 1'b0;
            meas_ovf_d   = 1'b0;
        end else begin
            meas_valid_d = meas_valid_q;
            meas_ovf_d   = meas_ovf_q;
        end

        case (state_q)
            ACQ: begin
                if (acc_stb) begin
                    cnt_stable_d = acc_val;
                    cnt_valid_d  = 1'b1;
                    timer_d      = '0;
                    acc_d        = '0;
                    state_d      = RUN;
                end else begin
                    state_d      = ACQ;
                end
            end
            RUN: begin
                if (change) begin
                    cnt_stable_d = acc_val;
                    wrap_d       = (acc_val < cnt_stable_q);
                end else begin
                    cnt_stable_d = cnt_stable_q;
                end
                // A load at window end overrides the transfer clear above
                if (timer_q == TMR_LAST) begin
                    timer_d      = '0;
                    acc_d        = '0;
                    meas_data_d  = sum_sat;
                    meas_valid_d = 1'b1;
                    meas_ovf_d   = meas_valid_q && !meas_ready;
                end else begin
                    timer_d      = timer_q + TMR_W'(1);
                    acc_d        = sum_sat;
                end
            end
            default: begin
                state_d = ACQ;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACQ;
            cnt_stable_q <= '0;
            cnt_valid_q  <= 1'b0;
            wrap_q       <= 1'b0;
            timer_q      <= '0;
            acc_q        <= '0;
            meas_data_q  <= '0;
            meas_valid_q <= 1'b0;
            meas_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_stable_q <= cnt_stable_d;
            cnt_valid_q  <= cnt_valid_d;
            wrap_q       <= wrap_d;
            timer_q      <= timer_d;
            acc_q        <= acc_d;
            meas_data_q  <= meas_data_d;
            meas_valid_q <= meas_valid_d;
            meas_ovf_q   <= meas_ovf_d;
        end
    end

    assign cnt_stable = cnt_stable_q;
    assign cnt_valid  = cnt_valid_q;
    assign wrap_pulse = wrap_q;
    assign meas_data  = meas_data_q;
    assign meas_valid = meas_valid_q;
    assign meas_ovf   = meas_ovf_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed bench: a 16-cycle-window instance for acquisition, stepping, glitch
// and handshake cases, and a 4-bit/64-cycle instance for saturation and reset.
module tb_ripple_count_sampler;

    logic        clk;
    logic        rst;
    logic [2:0]  rip;
    logic        ready;
    logic [2:0]  cnt_stable;
    logic        cnt_valid;
    logic        wrap_pulse;
    logic [15:0] meas_data;
    logic        meas_valid;
    logic        meas_ovf;

    logic [2:0]  rip_s;
    logic        ready_s;
    logic [2:0]  s_cnt_stable;
    logic        s_cnt_valid;
    logic        s_wrap_pulse;
    logic [3:0]  s_meas_data;
    logic        s_meas_valid;
    logic        s_meas_ovf;

    int checks;
    int errors;
    int wraps;
    int threes;

    ripple_count_sampler #(.WIN_CYCLES(16), .ACC_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .ripple_q   (rip),
        .cnt_stable (cnt_stable),
        .cnt_valid  (cnt_valid),
        .wrap_pulse (wrap_pulse),
        .meas_data  (meas_data),
        .meas_valid (meas_valid),
        .meas_ready (ready),
        .meas_ovf   (meas_ovf)
    );

    ripple_count_sampler #(.WIN_CYCLES(64), .ACC_W(4)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .ripple_q   (rip_s),
        .cnt_stable (s_cnt_stable),
        .cnt_valid  (s_cnt_valid),
        .wrap_pulse (s_wrap_pulse),
        .meas_data  (s_meas_data),
        .meas_valid (s_meas_valid),
        .meas_ready (ready_s),
        .meas_ovf   (s_meas_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " cnt_stable"},   32'(cnt_stable),     32'd0);
        chk({tag, " cnt_valid"},    32'(cnt_valid),      32'd0);
        chk({tag, " wrap"},         32'(wrap_pulse),     32'd0);
        chk({tag, " meas_data"},    32'(meas_data),      32'd0);
        chk({tag, " meas_valid"},   32'(meas_valid),     32'd0);
        chk({tag, " meas_ovf"},     32'(meas_ovf),       32'd0);
        chk({tag, " s_cnt_valid"},  32'(s_cnt_valid),    32'd0);
        chk({tag, " s_cnt_stable"}, 32'(s_cnt_stable),   32'd0);
        chk({tag, " s_meas_data"},  32'(s_meas_data),    32'd0);
        chk({tag, " s_meas_valid"}, 32'(s_meas_valid),   32'd0);
    endtask

    // Asynchronous assertion checked before any clock edge, then a clean release
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_zero(tag);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        rip     = 3'd5;
        rip_s   = 3'd0;
        ready   = 1'b0;
        ready_s = 1'b0;

        // Power-on reset and first acquisition of a held 5
        tick();
        chk_zero("por");
        rst = 1'b0;
        repeat (3) tick();
        chk("acq_not_yet_valid", 32'(cnt_valid), 32'd0);
        tick();
        chk("acq_valid",  32'(cnt_valid),  32'd1);
        chk("acq_value",  32'(cnt_stable), 32'd5);
        chk("acq_nowrap", 32'(wrap_pulse), 32'd0);

        // Step 0..7,0 every 4 cycles; two window ends with no consumer
        rip = 3'd0;
        do_reset("rst_b");
        repeat (4) tick();
        chk("stepB_acq", 32'(cnt_stable), 32'd0);
        wraps = 0;
        for (int i = 1; i <= 8; i++) begin
            rip = 3'(i);
            repeat (4) begin
                tick();
                wraps += int'(wrap_pulse);
            end
            chk("step_cnt", 32'(cnt_stable), 32'(i % 8));
            if (i == 4) begin
                chk("win1_data",  32'(meas_data),  32'd4);
                chk("win1_valid", 32'(meas_valid), 32'd1);
                chk("win1_ovf",   32'(meas_ovf),   32'd0);
            end
        end
        chk("wrap_now",   32'(wrap_pulse), 32'd1);
        chk("wrap_count", 32'(wraps),      32'd1);
        chk("win2_data",  32'(meas_data),  32'd4);
        chk("win2_valid", 32'(meas_valid), 32'd1);
        chk("win2_ovf",   32'(meas_ovf),   32'd1);

        // Consume the overwritten result
        ready = 1'b1;
        tick();
        chk("xfer_valid", 32'(meas_valid), 32'd0);
        chk("xfer_ovf",   32'(meas_ovf),   32'd0);
        ready = 1'b0;
        rip   = 3'd3;
        repeat (15) tick();
        chk("win3_data",  32'(meas_data),  32'd3);
        chk("win3_valid", 32'(meas_valid), 32'd1);
        chk("win3_ovf",   32'(meas_ovf),   32'd0);
        rip = 3'd5;
        repeat (15) tick();
        chk("win3_hold",  32'(meas_data),  32'd3);
        chk("win3_hold_v", 32'(meas_valid), 32'd1);

        // Transfer coincident with window end
        ready = 1'b1;
        tick();
        chk("sim_valid", 32'(meas_valid), 32'd1);
        chk("sim_data",  32'(meas_data),  32'd2);
        chk("sim_ovf",   32'(meas_ovf),   32'd0);
        ready = 1'b0;

        // Glitch: 1 -> 3 (one cycle) -> 2, and reset mid-operation
        rip = 3'd1;
        do_reset("rst_glitch");
        repeat (4) tick();
        chk("gl_acq", 32'(cnt_stable), 32'd1);
        rip = 3'd3;
        threes = 0;
        wraps  = 0;
        tick();
        rip = 3'd2;
        repeat (15) begin
            tick();
            if (cnt_stable == 3'd3) threes++;
            wraps += int'(wrap_pulse);
        end
        chk("gl_cnt",    32'(cnt_stable), 32'd2);
        chk("gl_threes", 32'(threes),     32'd0);
        chk("gl_wraps",  32'(wraps),      32'd0);
        chk("gl_data",   32'(meas_data),  32'd1);
        chk("gl_valid",  32'(meas_valid), 32'd1);

        // Saturation: +7 every 4 cycles over a 64-cycle window into 4 bits
        rip_s = 3'd0;
        do_reset("rst_sat");
        repeat (4) tick();
        chk("sat_acq", 32'(s_cnt_valid), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            rip_s = rip_s + 3'd7;
            repeat (4) tick();
        end
        chk("sat_data",  32'(s_meas_data),  32'd15);
        chk("sat_valid", 32'(s_meas_valid), 32'd1);
        chk("sat_ovf",   32'(s_meas_ovf),   32'd0);
        chk("sat_cnt",   32'(s_cnt_stable), 32'd0);

        // Reset mid-window, then reacquire
        repeat (5) tick();
        rip_s = 3'd4;
        do_reset("rst_mid");
        repeat (3) tick();
        chk("reacq_not_yet", 32'(s_cnt_valid), 32'd0);
        tick();
        chk("reacq_valid", 32'(s_cnt_valid),  32'd1);
        chk("reacq_value", 32'(s_cnt_stable), 32'd4);
        chk("reacq_meas",  32'(s_meas_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
